pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It works alongside the forwarding unit and covers the hazards forwarding cannot resolve:
- load-use stalls
- taken-branch flushes
- multi-cycle mul/div occupancy of EX
- data-memory wait states

It drives the PC, IF/ID, ID/EX and EX/MEM write-enable and flush controls.

Parameters:
MULDIV_CYCLES, 8, cycles a mul/div instruction occupies EX (legal range 1..64)
CNT_W, 6, mul/div counter width; must satisfy 2**CNT_W >= MULDIV_CYCLES

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
IF_IDRs  input  5  rs of instruction in ID
IF_IDRt  input  5  rt of instruction in ID
IF_IDUseRt  input  1  ID instruction reads rt as a source
ID_EXRt  input  5  destination rt of instruction in EX
ID_EXMemRead  input  1  EX instruction is a load
EX_MulDiv  input  1  EX instruction is mul/div
EX_BranchTaken  input  1  branch/jump in EX resolved taken
mem_ready  input  1  data memory completes access this cycle
PCWrite  output  1  PC update enable
IF_IDWrite  output  1  IF/ID register enable
ID_EXWrite  output  1  ID/EX register enable
EX_MEMWrite  output  1  EX/MEM register enable
IF_IDFlush  output  1  load NOP into IF/ID
ID_EXFlush  output  1  load bubble into ID/EX
EX_MEMFlush  output  1  load bubble into EX/MEM
muldiv_start  output  1  one-cycle start pulse to mul/div unit
muldiv_done  output  1  one-cycle pulse, result valid, EX releases

Behaviour:
- State machine has two states, RUN and MD_BUSY. Reset (rst_n low at clk edge) puts it in RUN with cnt=0.
- While rst_n is low, outputs are: all *Write=1, all *Flush=0, muldiv_start=0, muldiv_done=0.
- Outputs are combinational from state, cnt and inputs. State and cnt are registered.
- Default in RUN with no event: all *Write=1, all *Flush=0.
- Priority, highest first: memory freeze, mul/div, branch flush, load-use.
- Memory freeze (mem_ready=0, any state):
  - PCWrite, IF_IDWrite, ID_EXWrite and EX_MEMWrite are all 0.
  - All flushes are 0 and both pulses are 0.
  - State and cnt hold.
  - Lower-priority events are suppressed. They re-evaluate once mem_ready=1 because the stage registers are unchanged.
- Mul/div in RUN (EX_MulDiv=1):
  - muldiv_start=1.
  - If MULDIV_CYCLES==1: muldiv_done=1 in the same cycle, no freeze, stay in RUN.
  - Otherwise:
    - PCWrite, IF_IDWrite and ID_EXWrite are 0.
    - EX_MEMFlush=1 (bubble downstream).
    - cnt loads MULDIV_CYCLES-2 and the state goes to MD_BUSY.
- MD_BUSY:
  - While cnt!=0: same freeze and EX_MEMFlush, cnt decrements.
  - When cnt==0: freeze releases (normal writes), muldiv_done=1, state returns to RUN.
  - The mul/div instruction therefore occupies EX for exactly MULDIV_CYCLES cycles.
  - A back-to-back mul/div entering EX after done restarts the sequence with no gap cycle.
- EX_BranchTaken in RUN with no mul/div:
  - IF_IDFlush=1 and ID_EXFlush=1 for one cycle.
  - PCWrite=1 so the target loads.
  - Load-use detection is ignored that cycle because the ID instruction is squashed.
- Load-use in RUN, with no higher-priority event:
  - Detected when ID_EXMemRead && ID_EXRt!=0 && (ID_EXRt==IF_IDRs || (IF_IDUseRt && ID_EXRt==IF_IDRt)).
  - Response: PCWrite=0, IF_IDWrite=0, ID_EXFlush=1 for exactly one cycle.
  - The next cycle the load has moved to MEM and the forwarding unit resolves the dependency.
- EX_BranchTaken and EX_MulDiv are never both 1 (same EX instruction). If both are 1 anyway, mul/div wins and the assertion fires in simulation.
- Reset mid-MD_BUSY: next state is RUN, cnt=0, no muldiv_done pulse.

Optional Feature:
HAZ_STATS_EN
- Defined: extra outputs stall_cycles[31:0] and flush_events[15:0], both reset to 0.
  - stall_cycles increments on every cycle with PCWrite=0.
  - flush_events increments on every cycle with IF_IDFlush or ID_EXFlush asserted.
  - Both counters saturate at all-ones.
- Undefined: these ports and counters do not exist, and control behaviour is identical.

Decomposition:
- pipe_ctrl_pkg holds:
  - the state encoding (RUN=1'b0, MD_BUSY=1'b1)
  - the REG_ZERO=5'd0 constant
  - the default MULDIV_CYCLES
- The mul/div occupancy counter is a natural sub-module, muldiv_seq. It has load, decrement and zero-detect, and produces the start/done pulses.
- Priority resolution and load-use detection stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: lw writes $8 in EX (ID_EXMemRead=1, ID_EXRt=8), ID reads IF_IDRs=8 -> one cycle PCWrite=0, IF_IDWrite=0, ID_EXFlush=1, then normal. Repeat with ID_EXRt=0 -> no stall.
- Taken branch: EX_BranchTaken=1 for 1 cycle -> IF_IDFlush=ID_EXFlush=1 that cycle only, PCWrite=1. The same cycle also presents a load-use match -> no stall.
- Mul/div with MULDIV_CYCLES=8: EX_MulDiv=1 -> muldiv_start at cycle 0, freeze plus EX_MEMFlush for cycles 0-6, muldiv_done at cycle 7. Back-to-back mul/div -> second start at cycle 8.
- mem_ready=0 for 3 cycles in the middle of MD_BUSY -> all *Write=0 for those cycles, cnt holds, done is delayed by exactly 3 cycles.
- rst_n=0 at cycle 3 of MD_BUSY -> next cycle in RUN with all *Write=1, no done pulse. A fresh mul/div then takes the full 8 cycles.
- HAZ_STATS_EN: the load-use scenario plus one branch plus one 8-cycle mul/div -> stall_cycles=8, flush_events=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared encodings and constants for the pipeline hazard
//                controller and its mul/div occupancy sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef logic [0:0] state_t;
    typedef logic [4:0] reg_idx_t;

    localparam state_t   RUN               = 1'b0;
    localparam state_t   MD_BUSY           = 1'b1;
    localparam reg_idx_t REG_ZERO          = 5'd0;
    localparam int       DEF_MULDIV_CYCLES = 8;

endpackage : pipe_ctrl_pkg

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Pipeline-side hazard information and the stage enable/flush
//                controls returned by the hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_idx_t IF_IDRs;
    reg_idx_t IF_IDRt;
    logic     IF_IDUseRt;
    reg_idx_t ID_EXRt;
    logic     ID_EXMemRead;
    logic     EX_MulDiv;
    logic     EX_BranchTaken;
    logic     mem_ready;

    logic     PCWrite;
    logic     IF_IDWrite;
    logic     ID_EXWrite;
    logic     EX_MEMWrite;
    logic     IF_IDFlush;
    logic     ID_EXFlush;
    logic     EX_MEMFlush;
    logic     muldiv_start;
    logic     muldiv_done;

    // Pipeline datapath side
    modport master (
        output IF_IDRs, IF_IDRt, IF_IDUseRt, ID_EXRt, ID_EXMemRead,
               EX_MulDiv, EX_BranchTaken, mem_ready,
        input  PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite,
               IF_IDFlush, ID_EXFlush, EX_MEMFlush, muldiv_start, muldiv_done
    );

    // Hazard controller side
    modport slave (
        input  IF_IDRs, IF_IDRt, IF_IDUseRt, ID_EXRt, ID_EXMemRead,
               EX_MulDiv, EX_BranchTaken, mem_ready,
        output PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite,
               IF_IDFlush, ID_EXFlush, EX_MEMFlush, muldiv_start, muldiv_done
    );

endinterface : pipe_hazard_ctrl_if

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
//  Module      : muldiv_seq
//  Description : RUN/MD_BUSY sequencer that holds a mul/div instruction in EX
//                for MULDIV_CYCLES cycles and emits start/done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES,
    parameter int CNT_W         = 6
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic advance,
    input  wire logic md_req,
    output logic      md_busy,
    output logic      md_start,
    output logic      md_done,
    output logic      md_stall
);

    localparam bit               c_SINGLE = (MULDIV_CYCLES == 1);
    localparam logic [CNT_W-1:0] c_LOAD   = (MULDIV_CYCLES > 1) ? CNT_W'(MULDIV_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] c_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // advance low (memory wait) freezes the sequence in place
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        md_start = 1'b0;
        md_done  = 1'b0;
        md_stall = 1'b0;
        if (rst_n && advance) begin
            case (state_q)
                RUN: begin
                    if (md_req) begin
                        md_start = 1'b1;
                        if (c_SINGLE) begin
                            md_done = 1'b1;
                        end else begin
                            md_stall = 1'b1;
                            cnt_d    = c_LOAD;
                            state_d  = MD_BUSY;
                        end
                    end
                end
                MD_BUSY: begin
                    if (cnt_q != '0) begin
                        md_stall = 1'b1;
                        cnt_d    = cnt_q - c_ONE;
                    end else begin
                        md_done = 1'b1;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign md_busy = (state_q == MD_BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : muldiv_seq

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush sequencer for the 5-stage pipeline: memory wait,
//                mul/div occupancy, taken-branch flush and load-use stall.
//                Optional hazard statistics counters under HAZ_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES,
    parameter int CNT_W         = 6
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pipe_hazard_ctrl_if.slave  bus
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_events
`endif
);

    logic w_md_busy;
    logic w_md_start;
    logic w_md_done;
    logic w_md_stall;
    logic w_load_use;

    muldiv_seq #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_muldiv_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (bus.mem_ready),
        .md_req   (bus.EX_MulDiv),
        .md_busy  (w_md_busy),
        .md_start (w_md_start),
        .md_done  (w_md_done),
        .md_stall (w_md_stall)
    );

    assign w_load_use = bus.ID_EXMemRead && (bus.ID_EXRt != REG_ZERO) &&
                        ((bus.ID_EXRt == bus.IF_IDRs) ||
                         (bus.IF_IDUseRt && (bus.ID_EXRt == bus.IF_IDRt)));

    // Priority: memory freeze > mul/div > branch flush > load-use
    always_comb begin
        bus.PCWrite      = 1'b1;
        bus.IF_IDWrite   = 1'b1;
        bus.ID_EXWrite   = 1'b1;
        bus.EX_MEMWrite  = 1'b1;
        bus.IF_IDFlush   = 1'b0;
        bus.ID_EXFlush   = 1'b0;
        bus.EX_MEMFlush  = 1'b0;
        bus.muldiv_start = w_md_start;
        bus.muldiv_done  = w_md_done;
        if (rst_n) begin
            if (!bus.mem_ready) begin
                bus.PCWrite     = 1'b0;
                bus.IF_IDWrite  = 1'b0;
                bus.ID_EXWrite  = 1'b0;
                bus.EX_MEMWrite = 1'b0;
            end else if (w_md_busy || bus.EX_MulDiv) begin
                if (w_md_stall) begin
                    bus.PCWrite     = 1'b0;
                    bus.IF_IDWrite  = 1'b0;
                    bus.ID_EXWrite  = 1'b0;
                    bus.EX_MEMFlush = 1'b1;
                end
            end else if (bus.EX_BranchTaken) begin
                bus.IF_IDFlush = 1'b1;
                bus.ID_EXFlush = 1'b1;
            end else if (w_load_use) begin
                bus.PCWrite    = 1'b0;
                bus.IF_IDWrite = 1'b0;
                bus.ID_EXFlush = 1'b1;
            end
        end
    end

    a_branch_muldiv_excl : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.EX_BranchTaken && bus.EX_MulDiv));

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!bus.PCWrite && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if ((bus.IF_IDFlush || bus.ID_EXFlush) && (flush_events_q != '1)) begin
            flush_events_d = flush_events_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule : pipe_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Scoreboard testbench for pipe_hazard_ctrl (MULDIV_CYCLES=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int MD = 8;

    // {PCWrite, IF_IDWrite, ID_EXWrite, EX_MEMWrite,
    //  IF_IDFlush, ID_EXFlush, EX_MEMFlush, muldiv_start, muldiv_done}
    localparam logic [8:0] NORM     = 9'b1111_000_00;
    localparam logic [8:0] LU       = 9'b0011_010_00;
    localparam logic [8:0] BR       = 9'b1111_110_00;
    localparam logic [8:0] MD_START = 9'b0001_001_10;
    localparam logic [8:0] MD_FRZ   = 9'b0001_001_00;
    localparam logic [8:0] MD_DONE  = 9'b1111_000_01;
    localparam logic [8:0] MEMF     = 9'b0000_000_00;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    string      name_q[$];

    pipe_hazard_ctrl_if bus ();

`ifdef HAZ_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    pipe_hazard_ctrl #(
        .MULDIV_CYCLES (MD),
        .CNT_W         (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HAZ_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.IF_IDRs        = 5'd0;
        bus.IF_IDRt        = 5'd0;
        bus.IF_IDUseRt     = 1'b0;
        bus.ID_EXRt        = 5'd0;
        bus.ID_EXMemRead   = 1'b0;
        bus.EX_MulDiv      = 1'b0;
        bus.EX_BranchTaken = 1'b0;
        bus.mem_ready      = 1'b1;
    endtask

    task automatic set_load(input logic [4:0] ex_rt, input logic [4:0] rs,
                            input logic [4:0] rt, input logic use_rt);
        bus.ID_EXMemRead = 1'b1;
        bus.ID_EXRt      = ex_rt;
        bus.IF_IDRs      = rs;
        bus.IF_IDRt      = rt;
        bus.IF_IDUseRt   = use_rt;
    endtask

    // Push the expected vector, then capture the DUT outputs mid-cycle
    task automatic cyc(input logic [8:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        got_q.push_back({bus.PCWrite, bus.IF_IDWrite, bus.ID_EXWrite, bus.EX_MEMWrite,
                         bus.IF_IDFlush, bus.ID_EXFlush, bus.EX_MEMFlush,
                         bus.muldiv_start, bus.muldiv_done});
        @(posedge clk);
        #1;
    endtask

    task automatic md_full(input string pfx);
        cyc(MD_START, {pfx, "_start"});
        for (int i = 1; i < MD - 1; i++) cyc(MD_FRZ, $sformatf("%s_frz%0d", pfx, i));
        cyc(MD_DONE, {pfx, "_done"});
    endtask

    task automatic test_reset();
        logic [8:0] e, g; string n;
        idle();
        bus.EX_MulDiv = 1'b1;
        cyc(NORM, "rst_md_req");
        bus.mem_ready = 1'b0;
        set_load(5'd8, 5'd8, 5'd0, 1'b0);
        cyc(NORM, "rst_memf_lu");
        idle();
        rst_n = 1'b1;
        cyc(NORM, "post_rst_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
    endtask

`ifdef HAZ_STATS_EN
    task automatic test_stats();
        logic [8:0] e, g; string n;
        checks++;
        if (stall_cycles !== 32'd0 || flush_events !== 16'd0) begin
            failures++;
            $display("FAIL stats_reset got=%0d/%0d exp=0/0", stall_cycles, flush_events);
        end
        idle(); set_load(5'd8, 5'd8, 5'd0, 1'b0);
        cyc(LU, "st_lu");
        idle(); bus.EX_BranchTaken = 1'b1;
        cyc(BR, "st_br");
        idle(); bus.EX_MulDiv = 1'b1;
        md_full("st_md");
        idle();
        cyc(NORM, "st_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
        checks++;
        if (stall_cycles !== 32'd8) begin
            failures++; $display("FAIL stall_cycles got=%0d exp=8", stall_cycles);
        end
        checks++;
        if (flush_events !== 16'd2) begin
            failures++; $display("FAIL flush_events got=%0d exp=2", flush_events);
        end
    endtask
`endif

    task automatic test_load_use();
        logic [8:0] e, g; string n;
        idle(); set_load(5'd8, 5'd8, 5'd3, 1'b0);
        cyc(LU, "lu_rs");
        idle();
        cyc(NORM, "lu_release");
        set_load(5'd0, 5'd0, 5'd0, 1'b1);
        cyc(NORM, "lu_reg_zero");
        set_load(5'd9, 5'd3, 5'd9, 1'b1);
        cyc(LU, "lu_rt_used");
        set_load(5'd9, 5'd3, 5'd9, 1'b0);
        cyc(NORM, "lu_rt_unused");
        set_load(5'd9, 5'd3, 5'd4, 1'b1);
        cyc(NORM, "lu_no_match");
        idle(); bus.ID_EXRt = 5'd8; bus.IF_IDRs = 5'd8;
        cyc(NORM, "lu_not_load");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
    endtask

    task automatic test_branch();
        logic [8:0] e, g; string n;
        idle(); bus.EX_BranchTaken = 1'b1;
        cyc(BR, "br_plain");
        set_load(5'd8, 5'd8, 5'd0, 1'b0);
        cyc(BR, "br_over_lu");
        idle();
        cyc(NORM, "br_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] e, g; string n;
        idle(); bus.EX_MulDiv = 1'b1;
        md_full("md1");
        md_full("md2");
        idle();
        cyc(NORM, "md_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
    endtask

    task automatic test_mem_freeze();
        logic [8:0] e, g; string n;
        idle(); bus.EX_MulDiv = 1'b1;
        cyc(MD_START, "mf_start");
        for (int i = 1; i <= 2; i++) cyc(MD_FRZ, $sformatf("mf_frz%0d", i));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(MEMF, $sformatf("mf_wait%0d", i));
        bus.mem_ready = 1'b1;
        for (int i = 3; i <= 6; i++) cyc(MD_FRZ, $sformatf("mf_frz%0d", i));
        cyc(MD_DONE, "mf_done");
        idle(); set_load(5'd8, 5'd8, 5'd0, 1'b0); bus.mem_ready = 1'b0;
        cyc(MEMF, "mf_lu_hold");
        bus.mem_ready = 1'b1;
        cyc(LU, "mf_lu_reeval");
        idle(); bus.EX_MulDiv = 1'b1; bus.mem_ready = 1'b0;
        cyc(MEMF, "mf_md_hold");
        bus.mem_ready = 1'b1;
        md_full("mf_md");
        idle();
        cyc(NORM, "mf_after");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [8:0] e, g; string n;
        idle(); bus.EX_MulDiv = 1'b1;
        cyc(MD_START, "rm_start");
        for (int i = 1; i <= 2; i++) cyc(MD_FRZ, $sformatf("rm_frz%0d", i));
        rst_n = 1'b0;
        cyc(NORM, "rm_in_rst");
        rst_n = 1'b1; bus.EX_MulDiv = 1'b0;
        cyc(NORM, "rm_after_rst");
        bus.EX_MulDiv = 1'b1;
        md_full("rm_fresh");
        idle();
        cyc(NORM, "rm_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n = name_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL %s got=%b exp=%b", n, g, e); end
        end
    endtask

    initial begin
        test_reset();
`ifdef HAZ_STATS_EN
        test_stats();
`endif
        test_load_use();
        test_branch();
        test_back_to_back();
        test_mem_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl

`default_nettype wire
